ram_stream_reader: RTL and testbench
====================================

RAM_STREAM_READER -- requirements
Module: ram_stream_reader

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width (matches RAM WIDTH).
REQ-002 SHALL have parameter DEPTH, default 10, number of RAM address bits used.
REQ-003 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-005 SHALL have port start  in  1  one-cycle command strobe, sampled only in IDLE.
REQ-006 SHALL have port base  in  32  first word address of burst.
REQ-007 SHALL have port count  in  32  number of words to read.
REQ-008 SHALL have port busy  out  1  high whenever not IDLE.
REQ-009 SHALL have port done  out  1  one-cycle pulse at burst completion.
REQ-010 SHALL have port error  out  1  one-cycle pulse when a command is rejected.
REQ-011 SHALL have port ram_length  in  32  RAM word count from the RAM length output.
REQ-012 SHALL have port ram_address  out  32  RAM address.
REQ-013 SHALL have port ram_din  out  WIDTH  tied to zero.
REQ-014 SHALL have port ram_we  out  1  tied low.
REQ-015 SHALL have port ram_oe  out  1  high in cycles issuing a read.
REQ-016 SHALL have port ram_dout  in  WIDTH  RAM read data, valid one cycle after address.
REQ-017 SHALL have ports m_data out WIDTH, m_valid out 1, m_ready in 1, m_last out 1: output stream.

Function
REQ-018 SHALL implement states IDLE, RUN, DRAIN; IDLE->RUN on start with count>0; RUN->DRAIN after last address issued; DRAIN->IDLE when last beat accepted (m_valid&m_ready&m_last).
REQ-019 SHALL, on start with count==0, stay IDLE and pulse done the next cycle, emitting no beats.
REQ-020 SHALL ignore start while busy.
REQ-021 SHALL assume fixed RAM read latency of 1 cycle: data for address issued in cycle N captured from ram_dout in cycle N+1.
REQ-022 SHALL buffer returned words in a 2-entry FIFO and issue a read only when FIFO occupancy plus in-flight reads is below 2.
REQ-023 SHALL sustain one beat per cycle while m_ready is held high; first m_valid no earlier than 2 cycles after start.
REQ-024 SHALL hold m_data and m_last stable while m_valid high and m_ready low; no beat dropped or duplicated.
REQ-025 SHALL assert m_last only on the count-th beat.
REQ-026 SHALL increment the address by 1 per issued read, 32-bit, no wrap; upper bits beyond DEPTH passed through unchanged.
REQ-027 SHALL pulse done in the cycle after the last beat handshake; busy deasserts in that same cycle.

Reset
REQ-028 SHALL, on reset low at a clock edge, abort any burst, empty the FIFO, discard in-flight data, return to IDLE.
REQ-029 SHALL reset outputs: busy 0, done 0, error 0, m_valid 0, m_last 0, m_data 0, ram_oe 0, ram_address 0.

Configuration
REQ-030 SHALL, with RAM_STREAM_READER_BOUNDS_CHECK_EN defined, reject start when base+count (33-bit sum) exceeds ram_length: stay IDLE, pulse error next cycle, no reads.
REQ-031 SHALL, without the macro, accept every command, tie error to 0 and ignore ram_length.

Structure
REQ-032 SHALL place state encoding and the RAM read-latency constant (1) in shared package ram_stream_pkg.
REQ-033 SHALL implement the 2-entry buffer as sub-module ram_stream_fifo2 (push/pop/full/empty/count).

Verification
REQ-034 SHALL test base=0x10, count=4, m_ready=1 -> addresses 0x10..0x13 on consecutive cycles, 4 beats back-to-back, m_last on beat 4, done one cycle later.
REQ-035 SHALL test count=8 with m_ready toggling 1,0,0,1,... -> exactly 8 beats in address order, data stable during stalls, at most 2 reads outstanding.
REQ-036 SHALL test count=0 -> done pulse next cycle, m_valid never high, ram_oe never high.
REQ-037 SHALL test with macro: ram_length=1024, base=1020, count=8 -> error pulse, no reads; base=1016, count=8 -> accepted, done.
REQ-038 SHALL test reset low mid-burst at beat 3 of 10 -> next cycle all outputs at reset values; subsequent start base=0, count=2 completes normally.
REQ-039 SHALL test start asserted while busy -> ignored, current burst unaffected.

Source files
------------

// File: rtl/ram_stream_pkg.sv
// Shared state encoding and RAM timing constants for the RAM stream reader.
package ram_stream_pkg;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam int RD_LATENCY = 1;
  localparam int FIFO_DEPTH = 2;
endpackage

// File: rtl/ram_stream_fifo2.sv
// Two-entry FIFO holding RAM read data until the stream consumer accepts it.
module ram_stream_fifo2 #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty,
  output logic [1:0]       o_count
);
  logic [WIDTH-1:0] r_mem [2];
  logic             r_wr;
  logic             r_rd;
  logic [1:0]       r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr     <= 1'b0;
      r_rd     <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr] <= i_din;
        r_wr        <= ~r_wr;
      end
      if (i_pop) r_rd <= ~r_rd;
      r_cnt <= r_cnt + {1'b0, i_push} - {1'b0, i_pop};
    end
  end

  assign o_dout  = r_mem[r_rd];
  assign o_full  = (r_cnt == 2'd2);
  assign o_empty = (r_cnt == 2'd0);
  assign o_count = r_cnt;
endmodule

// File: rtl/ram_stream_reader.sv
// Burst reader: streams count words from a 1-cycle-latency RAM starting at base.
// Optional bounds check against ram_length: RAM_STREAM_READER_BOUNDS_CHECK_EN.
module ram_stream_reader
  import ram_stream_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      base,
  input  logic [31:0]      count,
  output logic             busy,
  output logic             done,
  output logic             error,
  input  logic [31:0]      ram_length,
  output logic [31:0]      ram_address,
  output logic [WIDTH-1:0] ram_din,
  output logic             ram_we,
  output logic             ram_oe,
  input  logic [WIDTH-1:0] ram_dout,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last
);
  state_t              r_state;
  logic [31:0]         r_addr;
  logic [31:0]         r_remain;
  logic [31:0]         r_beats;
  logic [RD_LATENCY:1] r_rd_vld;
  logic                r_done;
  logic                r_err;

  logic                w_issue;
  logic                w_pop;
  logic                w_push;
  logic                w_empty;
  logic                w_full_unused;
  logic                w_reject;
  logic [1:0]          w_fcnt;
  logic [2:0]          w_level;
  logic [RD_LATENCY:0] w_vld_pipe;
  logic                w_unused_depth;

  assign w_unused_depth = DEPTH[0];

`ifdef RAM_STREAM_READER_BOUNDS_CHECK_EN
  assign w_reject = ({1'b0, base} + {1'b0, count}) > {1'b0, ram_length};
`else
  logic w_unused_len;
  assign w_reject     = 1'b0;
  assign w_unused_len = ^ram_length;
`endif

  // Credit: words that will sit in the FIFO after this edge plus reads
  // still in the RAM pipe must leave room for one more issue.
  assign w_pop      = m_valid & m_ready;
  assign w_level    = {1'b0, w_fcnt} + 3'($countones(r_rd_vld)) - {2'b00, w_pop};
  assign w_issue    = (r_state == S_RUN) && (w_level < 3'(FIFO_DEPTH));
  assign w_vld_pipe = {r_rd_vld, w_issue};
  assign w_push     = w_vld_pipe[RD_LATENCY];

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_remain <= '0;
      r_beats  <= '0;
      r_rd_vld <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_rd_vld <= w_vld_pipe[RD_LATENCY-1:0];
      if (w_pop) r_beats <= r_beats - 32'd1;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (count == 32'd0) begin
              r_done <= 1'b1;
            end else if (w_reject) begin
              r_err <= 1'b1;
            end else begin
              r_state  <= S_RUN;
              r_addr   <= base;
              r_remain <= count;
              r_beats  <= count;
            end
          end
        end
        S_RUN: begin
          if (w_issue) begin
            r_addr   <= r_addr + 32'd1;
            r_remain <= r_remain - 32'd1;
            if (r_remain == 32'd1) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_pop && m_last) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  ram_stream_fifo2 #(.WIDTH(WIDTH)) u_fifo (
    .i_clk   (clk),
    .i_reset (reset),
    .i_push  (w_push),
    .i_din   (ram_dout),
    .i_pop   (w_pop),
    .o_dout  (m_data),
    .o_full  (w_full_unused),
    .o_empty (w_empty),
    .o_count (w_fcnt)
  );

  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign error       = r_err;
  assign ram_address = r_addr;
  assign ram_oe      = w_issue;
  assign ram_we      = 1'b0;
  assign ram_din     = '0;
  assign m_valid     = ~w_empty;
  assign m_last      = m_valid && (r_beats == 32'd1);
endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader with a behavioural 1-cycle-latency RAM.
`timescale 1ns/1ps
module tb_ram_stream_reader;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             m_ready = 1'b0;
  logic [31:0]      base = '0;
  logic [31:0]      count = '0;
  logic [31:0]      ram_length = 32'd1024;
  logic             busy, done, error, ram_we, ram_oe, m_valid, m_last;
  logic [31:0]      ram_address;
  logic [WIDTH-1:0] ram_din, m_data;
  logic [WIDTH-1:0] ram_dout = '0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] iss_q[$];
  logic [31:0] beat_d[$];
  logic        beat_l[$];
  int          n_oe, n_valid, n_unstable, max_out;
  logic        p_stall = 1'b0;
  logic        p_last  = 1'b0;
  logic [31:0] p_data  = '0;

  always #5 clk = ~clk;

  ram_stream_reader #(.WIDTH(WIDTH), .DEPTH(10)) dut (
    .clk(clk), .reset(reset), .start(start), .base(base), .count(count),
    .busy(busy), .done(done), .error(error), .ram_length(ram_length),
    .ram_address(ram_address), .ram_din(ram_din), .ram_we(ram_we),
    .ram_oe(ram_oe), .ram_dout(ram_dout), .m_data(m_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
  );

  function automatic logic [31:0] rd(input logic [31:0] a);
    return 32'hD000_0000 ^ a;
  endfunction

  always @(posedge clk) if (ram_oe) ram_dout <= rd(ram_address);

  always @(negedge clk) begin
    if (ram_oe) begin iss_q.push_back(ram_address); n_oe++; end
    if (m_valid) n_valid++;
    if (m_valid && m_ready) begin beat_d.push_back(m_data); beat_l.push_back(m_last); end
    if (p_stall && (!m_valid || m_data !== p_data || m_last !== p_last)) n_unstable++;
    p_stall = m_valid && !m_ready;
    p_data  = m_data;
    p_last  = m_last;
    if (iss_q.size() - beat_d.size() > max_out) max_out = iss_q.size() - beat_d.size();
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clr;
    iss_q.delete(); beat_d.delete(); beat_l.delete();
    n_oe = 0; n_valid = 0; n_unstable = 0; max_out = 0; p_stall = 1'b0;
  endtask

  task automatic go(input logic [31:0] b, input logic [31:0] c);
    base = b; count = c; start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (!done && k < budget) begin tick; k++; end
    chk("done_seen", 32'(done), 32'd1);
  endtask

  task automatic chk_burst(input string tag, input logic [31:0] b, input int n);
    chk({tag, "_nbeats"}, 32'(beat_d.size()), 32'(n));
    chk({tag, "_nissue"}, 32'(iss_q.size()), 32'(n));
    for (int i = 0; i < n && i < beat_d.size(); i++) begin
      chk({tag, "_data"}, beat_d[i], rd(b + 32'(i)));
      chk({tag, "_last"}, 32'(beat_l[i]), 32'(i == n - 1));
    end
    for (int i = 0; i < n && i < iss_q.size(); i++)
      chk({tag, "_addr"}, iss_q[i], b + 32'(i));
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_busy"},  32'(busy), 32'd0);
    chk({tag, "_done"},  32'(done), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
    chk({tag, "_valid"}, 32'(m_valid), 32'd0);
    chk({tag, "_last"},  32'(m_last), 32'd0);
    chk({tag, "_data"},  m_data, 32'd0);
    chk({tag, "_oe"},    32'(ram_oe), 32'd0);
    chk({tag, "_addr"},  ram_address, 32'd0);
  endtask

  initial begin
    logic [3:0] pat;
    int k;
    int hs;

    reset = 1'b0;
    repeat (3) tick;
    chk_reset_outs("rst");
    chk("rst_we", 32'(ram_we), 32'd0);
    reset = 1'b1;
    tick;

    // 4-word burst, consumer always ready
    clr; m_ready = 1'b1;
    go(32'h10, 32'd4);
    chk("b4_oe1", 32'(ram_oe), 32'd1);
    chk("b4_addr1", ram_address, 32'h10);
    chk("b4_valid1", 32'(m_valid), 32'd0);
    tick;
    chk("b4_addr2", ram_address, 32'h11);
    chk("b4_valid2", 32'(m_valid), 32'd0);
    tick;
    chk("b4_addr3", ram_address, 32'h12);
    chk("b4_valid3", 32'(m_valid), 32'd1);
    chk("b4_data3", m_data, rd(32'h10));
    wait_done(20);
    chk("b4_busy_at_done", 32'(busy), 32'd0);
    tick;
    chk("b4_done_pulse", 32'(done), 32'd0);
    chk("b4_b2b", 32'(n_valid), 32'd4);
    chk_burst("b4", 32'h10, 4);

    // 8-word burst with ready pattern 1,0,0,1
    clr; pat = 4'b1001; k = 0;
    go(32'h40, 32'd8);
    while (!done && k < 200) begin m_ready = pat[k % 4]; tick; k++; end
    chk("b8_done_seen", 32'(done), 32'd1);
    m_ready = 1'b1;
    tick;
    chk("b8_unstable", 32'(n_unstable), 32'd0);
    chk("b8_outstanding_le2", 32'(max_out <= 2), 32'd1);
    chk_burst("b8", 32'h40, 8);

    // zero-length command
    clr;
    go(32'h30, 32'd0);
    chk("z_done", 32'(done), 32'd1);
    chk("z_busy", 32'(busy), 32'd0);
    tick;
    chk("z_done_drop", 32'(done), 32'd0);
    chk("z_oe_cycles", 32'(n_oe), 32'd0);
    chk("z_valid_cycles", 32'(n_valid), 32'd0);

    // start while busy is ignored
    clr; m_ready = 1'b1;
    go(32'h80, 32'd3);
    base = 32'h200; count = 32'd5; start = 1'b1;
    tick;
    start = 1'b0;
    wait_done(20);
    tick;
    chk("sb_busy_after", 32'(busy), 32'd0);
    chk_burst("sb", 32'h80, 3);

`ifdef RAM_STREAM_READER_BOUNDS_CHECK_EN
    clr;
    go(32'd1020, 32'd8);
    chk("bc_err", 32'(error), 32'd1);
    chk("bc_busy", 32'(busy), 32'd0);
    tick;
    chk("bc_err_drop", 32'(error), 32'd0);
    chk("bc_no_reads", 32'(n_oe), 32'd0);
    clr;
    go(32'd1016, 32'd8);
    chk("bc_ok_err", 32'(error), 32'd0);
    wait_done(40);
    tick;
    chk_burst("bc_ok", 32'd1016, 8);
`else
    clr;
    go(32'd1020, 32'd8);
    chk("nb_busy", 32'(busy), 32'd1);
    chk("nb_err", 32'(error), 32'd0);
    wait_done(40);
    tick;
    chk_burst("nb", 32'd1020, 8);
`endif

    // reset in the cycle of beat 3 of 10
    clr; m_ready = 1'b1; hs = 0; k = 0;
    go(32'h100, 32'd10);
    while (k < 40) begin
      if (m_valid && m_ready) hs++;
      if (hs == 3) break;
      tick; k++;
    end
    chk("mr_reached_beat3", 32'(hs), 32'd3);
    reset = 1'b0;
    tick;
    chk_reset_outs("mr");
    reset = 1'b1;
    tick;
    clr;
    go(32'h0, 32'd2);
    wait_done(20);
    tick;
    chk_burst("mr_after", 32'h0, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
